// File: rtl/icache_tag_ctrl_if.sv
`timescale 1ns/1ps
// Purpose : fetch-side bundle for icache_tag_ctrl (lookup request, lookup result, fill, invalidate).
// Latency : none, wires only.
// Backpressure: lk_ready / fill_ready are driven by the controller; results carry no backpressure.
// Ports   : master = fetch pipeline side, slave = tag controller side.
interface icache_tag_ctrl_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
);
  logic                   lk_valid;
  logic                   lk_ready;
  logic [ADDR_WIDTH-1:0]  lk_addr;
  logic                   res_valid;
  logic                   res_hit;
  logic [INDEX_WIDTH-1:0] res_index;
  logic                   fill_en;
  logic                   fill_ready;
  logic [ADDR_WIDTH-1:0]  fill_addr;
  logic                   inv_req;
  logic                   busy;

  modport master (
    output lk_valid, lk_addr, fill_en, fill_addr, inv_req,
    input  lk_ready, res_valid, res_hit, res_index, fill_ready, busy
  );

  modport slave (
    input  lk_valid, lk_addr, fill_en, fill_addr, inv_req,
    output lk_ready, res_valid, res_hit, res_index, fill_ready, busy
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
`timescale 1ns/1ps
// Purpose : owns both ports of the ICACHE_TAG0 tag RAM: pipelined hit/miss lookup, line-fill tag writes, invalidate-all sweeps.
// Latency : lookup accepted at edge N -> res_valid in the cycle after edge N+1; fills write at the accepting edge; sweep 256 cycles.
// Backpressure: lk_ready/fill_ready low while sweeping; lk_ready also drops on a same-index fill (default build); results are never stalled.
// Ports   : clk/rst plain (rst async active-high, also resets the RAM ports); bus = slave side of icache_tag_ctrl_if;
//           tag_wr_* = RAM write port, tag_rd_addr/tag_rd_data = RAM read port (data one cycle after the address edge).
// Option  : define ICACHE_TAG_BYPASS_EN to forward a same-cycle same-index fill word into the lookup instead of stalling it.
module icache_tag_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_tag_ctrl_if.slave       bus,
  output logic                   tag_wr_en,
  output logic [INDEX_WIDTH-1:0] tag_wr_addr,
  output logic [TAG_WIDTH:0]     tag_wr_data,
  output logic [INDEX_WIDTH-1:0] tag_rd_addr,
  input  logic [TAG_WIDTH:0]     tag_rd_data
);

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;

  logic                   lk_ready;
  logic                   fill_ready;
  logic                   busy;
  logic                   lk_acc;
  logic                   same_idx;

  logic [INDEX_WIDTH-1:0] lk_idx, fill_idx;
  logic [TAG_WIDTH-1:0]   lk_tag, fill_tag;

  // Stage 1: lookup whose RAM read is in flight.
  logic                   s1_vld_q;
  logic [TAG_WIDTH-1:0]   s1_tag_q;
  logic [INDEX_WIDTH-1:0] s1_idx_q;
  logic [TAG_WIDTH:0]     s1_word;
  logic                   s1_hit;

  logic                   res_valid_q;
  logic                   res_hit_q;
  logic [INDEX_WIDTH-1:0] res_index_q;

  logic                   unused_offset_bits;

  assign lk_idx   = bus.lk_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign lk_tag   = bus.lk_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign fill_idx = bus.fill_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign fill_tag = bus.fill_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  assign unused_offset_bits = ^{bus.lk_addr[OFFSET_WIDTH-1:0], bus.fill_addr[OFFSET_WIDTH-1:0]};

  // The read address follows the request directly so the RAM samples it at the accepting edge.
  assign tag_rd_addr = lk_idx;

  assign same_idx = bus.fill_en && (fill_idx == lk_idx);
  assign lk_acc   = bus.lk_valid && lk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    tag_wr_en   = 1'b0;
    tag_wr_addr = fill_idx;
    tag_wr_data = {1'b1, fill_tag};
    lk_ready    = 1'b0;
    fill_ready  = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        busy        = 1'b1;
        tag_wr_en   = 1'b1;
        tag_wr_addr = sweep_cnt_q;
        tag_wr_data = '0;
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        fill_ready = 1'b1;
        tag_wr_en  = bus.fill_en;
`ifdef ICACHE_TAG_BYPASS_EN
        lk_ready   = 1'b1;
`else
        // A same-index fill would be written at the very edge the RAM reads; hold the lookup one cycle.
        lk_ready   = !same_idx;
`endif
        // Waiting for stage 1 to drain is not needed for correctness of its read (already sampled),
        // but a lookup in stage 1 must not be accepted into a sweep window behind another one.
        if (bus.inv_req && !s1_vld_q) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_SWEEP;
        sweep_cnt_d = '0;
      end
    endcase
  end

`ifdef ICACHE_TAG_BYPASS_EN
  // Same-cycle fill to the looked-up index: the RAM returns the old word, so carry the fill word instead.
  logic                 s1_byp_q;
  logic [TAG_WIDTH-1:0] s1_fill_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_byp_q      <= 1'b0;
      s1_fill_tag_q <= '0;
    end else if (lk_acc) begin
      s1_byp_q      <= same_idx;
      s1_fill_tag_q <= fill_tag;
    end
  end

  assign s1_word = s1_byp_q ? {1'b1, s1_fill_tag_q} : tag_rd_data;
`else
  assign s1_word = tag_rd_data;
`endif

  assign s1_hit = s1_word[TAG_WIDTH] && (s1_word[TAG_WIDTH-1:0] == s1_tag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_tag_q <= '0;
      s1_idx_q <= '0;
    end else begin
      s1_vld_q <= lk_acc;
      if (lk_acc) begin
        s1_tag_q <= lk_tag;
        s1_idx_q <= lk_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
    end else begin
      res_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        res_hit_q   <= s1_hit;
        res_index_q <= s1_idx_q;
      end
    end
  end

  assign bus.lk_ready   = lk_ready;
  assign bus.fill_ready = fill_ready;
  assign bus.busy       = busy;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hit    = res_hit_q;
  assign bus.res_index  = res_index_q;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for icache_tag_ctrl with a behavioural tag RAM and a set-array reference model.
// Latency : n/a.
// Backpressure: lookups are held until accepted; fills are single-cycle requests.
module tb_icache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tag_wr_en;
  logic [7:0]  tag_wr_addr;
  logic [20:0] tag_wr_data;
  logic [7:0]  tag_rd_addr;
  logic [20:0] tag_rd_data;

  always #5 clk = ~clk;

  icache_tag_ctrl_if bus ();

  icache_tag_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .tag_wr_en   (tag_wr_en),
    .tag_wr_addr (tag_wr_addr),
    .tag_wr_data (tag_wr_data),
    .tag_rd_addr (tag_rd_addr),
    .tag_rd_data (tag_rd_data)
  );

  // Tag RAM: read-before-write, read data one cycle after the address edge.
  logic [20:0] ram [256];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_rd_data <= '0;
    end else begin
      tag_rd_data <= ram[tag_rd_addr];
      if (tag_wr_en) ram[tag_wr_addr] <= tag_wr_data;
    end
  end

  // Reference model: per-set valid/tag, sweep cycles remaining, expected result queue.
  typedef struct {
    int         due;
    bit         hit;
    logic [7:0] idx;
  } res_t;

  bit          mvalid [256];
  logic [19:0] mtag   [256];
  int          sweep_left;
  int          cyc;
  res_t        q[$];
  int          vectors;
  int          miscompares;
  bit          last_lk_acc;

`ifdef ICACHE_TAG_BYPASS_EN
  localparam int SAME_LAT = 2;
`else
  localparam int SAME_LAT = 3;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sweep_left = 256;
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    bit          run, exp_rdy, lk_acc, fill_acc, pend, ev, inv;
    logic [7:0]  li, fi;
    logic [19:0] lt, ft;
    res_t        r;
    @(negedge clk);
    run = (sweep_left == 0) && !rst;
    li  = bus.lk_addr[11:4];
    lt  = bus.lk_addr[31:12];
    fi  = bus.fill_addr[11:4];
    ft  = bus.fill_addr[31:12];
    inv = bus.inv_req;
    exp_rdy = run;
`ifndef ICACHE_TAG_BYPASS_EN
    if (bus.fill_en && fi == li) exp_rdy = 1'b0;
`endif
    chk("busy", bus.busy, !run);
    chk("lk_ready", bus.lk_ready, exp_rdy);
    chk("fill_ready", bus.fill_ready, run);
    chk("tag_rd_addr", tag_rd_addr, li);
    if (!run) begin
      chk("sweep_wr_en", tag_wr_en, 1);
      chk("sweep_wr_addr", tag_wr_addr, 256 - sweep_left);
      chk("sweep_wr_data", tag_wr_data, 0);
    end else begin
      chk("fill_wr_en", tag_wr_en, bus.fill_en);
      if (bus.fill_en) begin
        chk("fill_wr_addr", tag_wr_addr, fi);
        chk("fill_wr_data", tag_wr_data, {1'b1, ft});
      end
    end
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("res_valid", bus.res_valid, ev);
    if (ev) begin
      r = q.pop_front();
      chk("res_hit", bus.res_hit, r.hit);
      chk("res_index", bus.res_index, r.idx);
    end
    lk_acc   = bus.lk_valid && exp_rdy;
    fill_acc = bus.fill_en && run;
    pend     = (q.size() > 0) && (q[q.size()-1].due == cyc + 1);
    @(posedge clk);
    cyc++;
    last_lk_acc = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (fill_acc) begin
        mvalid[fi] = 1'b1;
        mtag[fi]   = ft;
      end
      if (lk_acc) begin
        r.due = cyc + 1;
        r.hit = mvalid[li] && (mtag[li] === lt);
        r.idx = li;
        q.push_back(r);
        last_lk_acc = 1'b1;
      end
      if (sweep_left > 0) begin
        sweep_left--;
      end else if (inv && !pend) begin
        sweep_left = 256;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] a);
    int n;
    bus.lk_valid = 1'b1;
    bus.lk_addr  = a;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_lk_acc && n < 8);
    bus.lk_valid = 1'b0;
    if (!last_lk_acc) chk("lookup_accept_timeout", 0, 1);
  endtask

  task automatic fill(input logic [31:0] a);
    bus.fill_en   = 1'b1;
    bus.fill_addr = a;
    step();
    bus.fill_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      step();
      n++;
    end
    if (bus.busy) chk("sweep_timeout", 1, 0);
  endtask

  logic [19:0] tags [256];
  logic [19:0] pool [4];
  int          n, cnt;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; last_lk_acc = 1'b0;
    bus.lk_valid = 1'b0; bus.lk_addr = '0;
    bus.fill_en  = 1'b0; bus.fill_addr = '0;
    bus.inv_req  = 1'b0;
    #1 rst = 1'b1;
    model_reset();

    // Reset state.
    repeat (3) step();
    chk("rst_res_hit", bus.res_hit, 0);
    chk("rst_res_index", bus.res_index, 0);
    chk("rst_wr_en", tag_wr_en, 1);
    rst = 1'b0;

    // Power-up sweep length.
    n = 0;
    while (bus.busy && n < 300) begin step(); n++; end
    chk("sweep_len", n, 256);

    // First lookup after sweep: miss at index 0x23, latency 2.
    lookup(32'h0000_1230);
    step();
    chk("lat2_valid", bus.res_valid, 1);
    chk("lat2_hit", bus.res_hit, 0);
    chk("lat2_index", bus.res_index, 8'h23);

    // Fill then hit, unrelated tag misses.
    fill(32'hABCD_E120);
    step();
    lookup(32'hABCD_E12C);
    step();
    chk("fill_hit", bus.res_hit, 1);
    chk("fill_index", bus.res_index, 8'h12);
    lookup(32'h1111_1120);
    step();
    chk("other_miss", bus.res_hit, 0);

    // Fill every set, then 256 back-to-back lookups.
    for (int i = 0; i < 256; i++) begin
      tags[i] = 20'($urandom);
      fill({tags[i], 8'(i), 4'h0});
    end
    cnt = 0;
    bus.lk_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.lk_addr = {tags[i], 8'(i), 4'(i)};
      step();
      if (bus.res_valid && bus.res_hit) cnt++;
    end
    bus.lk_valid = 1'b0;
    repeat (2) begin
      step();
      if (bus.res_valid && bus.res_hit) cnt++;
    end
    chk("b2b_hits", cnt, 256);

    // Invalidate with a lookup in flight: in-flight hit, then miss after sweep.
    step();
    bus.inv_req  = 1'b1;
    bus.lk_valid = 1'b1;
    bus.lk_addr  = {tags[5], 8'd5, 4'h0};
    step();
    bus.inv_req  = 1'b0;
    bus.lk_valid = 1'b0;
    step();
    chk("inflight_valid", bus.res_valid, 1);
    chk("inflight_hit", bus.res_hit, 1);
    chk("inv_busy", bus.busy, 1);
    wait_idle();
    lookup({tags[5], 8'd5, 4'h0});
    step();
    chk("post_inv_miss", bus.res_hit, 0);

    // Same-cycle fill and lookup to one index.
    bus.fill_en   = 1'b1;
    bus.fill_addr = 32'h5555_5340;
    bus.lk_valid  = 1'b1;
    bus.lk_addr   = 32'h5555_5340;
    n = 0;
    do begin
      step();
      n++;
      bus.fill_en = 1'b0;
      if (last_lk_acc) bus.lk_valid = 1'b0;
    end while (!bus.res_valid && n < 6);
    bus.lk_valid = 1'b0;
    chk("same_lat", n, SAME_LAT);
    chk("same_hit", bus.res_hit, 1);
    chk("same_index", bus.res_index, 8'h34);

    // Randomized traffic over a small index/tag space to force collisions.
    for (int i = 0; i < 4; i++) pool[i] = 20'($urandom);
    for (int i = 0; i < 1500; i++) begin
      bus.lk_valid  = ($urandom_range(0, 3) != 0);
      bus.lk_addr   = {pool[$urandom_range(0, 3)], 8'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      bus.fill_en   = ($urandom_range(0, 2) == 0);
      bus.fill_addr = {pool[$urandom_range(0, 3)], 8'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      bus.inv_req   = ($urandom_range(0, 199) == 0);
      step();
    end
    bus.lk_valid = 1'b0; bus.fill_en = 1'b0; bus.inv_req = 1'b0;
    step();
    step();
    wait_idle();

    // Reset with a lookup pending: result is dropped, sweep restarts at 0.
    lookup(32'h0000_0450);
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    chk("rst_pend_valid", bus.res_valid, 0);
    rst = 1'b0;
    chk("restart_addr0", tag_wr_addr, 0);
    wait_idle();

    // Reset at sweep count 100.
    bus.inv_req = 1'b1;
    step();
    bus.inv_req = 1'b0;
    repeat (100) step();
    chk("mid_sweep_addr", tag_wr_addr, 100);
    rst = 1'b1;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    chk("restart_addr1", tag_wr_addr, 0);
    n = 0;
    while (bus.busy && n < 300) begin step(); n++; end
    chk("restart_len", n, 256);
    lookup(32'hABCD_E120);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Controller that owns both ports of the `ICACHE_TAG0` tag RAM (256 entries × 21 bits, simple dual-port, unregistered read output). It presents a pipelined lookup port to the instruction-cache core and returns hit/miss. It accepts line-fill tag writes and runs invalidate-all sweeps after reset and on request. It sits between the I-cache fetch pipeline and the tag RAM instance.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: fetch address width.
- `INDEX_WIDTH`, 8: tag RAM address width (256 sets).
- `OFFSET_WIDTH`, 4: line-offset bits (16-byte line).
- `TAG_WIDTH`, 20: `ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH`; RAM word = {valid, tag} = 21 bits.

Ports:
- `clk` in 1: single clock, also drives the RAM `wr_clk`/`rd_clk`.
- `rst` in 1: asynchronous, active-high reset; also drives the RAM `wr_rst`/`rd_rst`.
- `lk_valid` in 1: lookup request.
- `lk_ready` out 1: lookup accepted when `lk_valid & lk_ready`.
- `lk_addr` in 32: fetch address.
- `res_valid` out 1: one-cycle result strobe.
- `res_hit` out 1: tag match with valid set.
- `res_index` out 8: set index of the result.
- `fill_en` in 1: write tag for `fill_addr`, valid=1.
- `fill_ready` out 1: fill accepted when `fill_en & fill_ready`.
- `fill_addr` in 32: address of the filled line.
- `inv_req` in 1: invalidate-all request (level; sampled when idle).
- `busy` out 1: sweep in progress.
- `tag_wr_en` out 1, `tag_wr_addr` out 8, `tag_wr_data` out 21: RAM write port.
- `tag_rd_addr` out 8, `tag_rd_data` in 21: RAM read port. Data is valid in the cycle after the edge that samples the address.

## Operation
- Index = `addr[11:4]`; tag = `addr[31:12]`; RAM word bit 20 = valid, bits 19:0 = tag.
- FSM states:
  - SWEEP: entered on reset. Counter 0→255; `tag_wr_en`=1, `tag_wr_addr`=counter, `tag_wr_data`=0. After writing 255 → RUN.
  - RUN: RUN → SWEEP when `inv_req`=1 and no result is pending; the counter is cleared to 0.
- `busy` = (state==SWEEP). `lk_ready`=0 and `fill_ready`=0 in SWEEP.
- Lookup stage 0:
  - `tag_rd_addr` = `lk_addr[11:4]` (combinational).
  - On accept, register `lk_addr[31:12]`, the index and a stage-1 valid.
- Lookup stage 1:
  - hit = `tag_rd_data[20] & (tag_rd_data[19:0]==stored tag)`.
  - Register into `res_hit`/`res_index`; pulse `res_valid`.
- Fill in RUN: `tag_wr_en`=1, `tag_wr_addr`=`fill_addr[11:4]`, `tag_wr_data`={1,`fill_addr[31:12]`} the same cycle. `fill_ready`=1 in RUN.
- `inv_req` asserted in SWEEP is ignored. A lookup already in stage 1 when a sweep starts completes with the pre-sweep RAM contents.
- Back-to-back lookups are sustained at 1 per cycle; there is no backpressure on results.
- Same-cycle fill and lookup to the same index is a read-during-write hazard; see Configuration.
- Fill to index X in the cycle after a lookup to X was accepted: the lookup returns the old (pre-fill) tag.

## Timing
- Reset values:
  - `lk_ready`=0, `fill_ready`=0, `busy`=1.
  - `res_valid`=0, `res_hit`=0, `res_index`=0.
  - `tag_wr_en`=1 (the sweep begins immediately), `tag_wr_addr`=0, `tag_wr_data`=0.
- Sweep takes 256 cycles. `busy` falls, and `lk_ready`/`fill_ready` rise, on the edge after the write to 255.
- Lookup accepted at edge N → `res_valid` high for exactly the cycle after edge N+1. Latency is 2 edges.
- Fill accepted at edge N is written at edge N. A lookup to that index accepted at edge N+1 or later sees the new tag.
- `rst` asserted mid-sweep or mid-lookup:
  - The pending result is discarded.
  - The sweep restarts at index 0.

## Configuration
- `ICACHE_TAG_BYPASS_EN` defined: on a same-cycle fill and lookup accept to the same index, stage 1 uses the fill word instead of `tag_rd_data`, so the result is a hit. `lk_ready`=1 throughout RUN.
- Not defined: `lk_ready` = RUN & ~(`fill_en` & `fill_addr[11:4]`==`lk_addr[11:4]`). The lookup stalls one cycle and then reads the written tag.

## Test plan
- Reset release → `busy`=1 for 256 cycles with `tag_wr_addr` 0..255 and data 0. Then a lookup to 0x0000_1230 → `res_hit`=0, `res_index`=0x23, 2-cycle latency.
- Fill 0xABCD_E120, then lookup 0xABCD_E12C two cycles later → `res_hit`=1, `res_index`=0x12. Lookup 0x1111_1120 → `res_hit`=0.
- 256 back-to-back lookups after filling all sets → 256 consecutive `res_valid` pulses, all hits, indexes in order.
- `inv_req` pulse after fills → 256-cycle sweep. A lookup in flight at sweep start still returns a hit. The same lookup after the sweep → miss.
- Same-cycle fill and lookup of 0x5555_5340 → with the macro: `res_hit`=1 at latency 2. Without it: `lk_ready`=0 for 1 cycle, then `res_hit`=1 at latency 3 from the first request.
- Assert `rst` at sweep count 100 and during a pending lookup → no `res_valid`. After release, the sweep restarts from `tag_wr_addr`=0.
